// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
// Provides the datapath width, the instruction size in bytes and the
// packed {inst, pc} entry that is buffered between imem and decode.
package fetch_unit_pkg;

  localparam int BIT_WIDTH  = 32;
  localparam int INST_BYTES = 4;

  typedef struct packed {
    logic [BIT_WIDTH-1:0] inst;
    logic [BIT_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Purpose: generic synchronous FIFO with flush and head/count outputs.
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: the producer must respect count; a push while full is dropped.
// Ports: push/push_data write the tail, pop removes the head (ignored
// when empty), flush empties the FIFO and wins over push/pop, count is
// the occupancy and head is the oldest entry (reset contents are 0).
module fetch_unit_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign do_push = push && !full;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (nreset && push && !flush) begin
      assert (!full) else $error("fetch fifo overflow");
    end
  end
`endif

endmodule

// File: rtl/fetch_unit.sv
// Purpose: instruction fetch; sequential imem reads buffered for decode.
// Latency: request in cycle N -> out_valid in N+2; redirect in R -> out_valid for target in R+3.
// Backpressure: imem requests stop once buffered + in-flight words fill the FIFO.
// Ports: clk/nreset; imem_req/imem_addr/imem_rdata to the 1-cycle imem;
// out_valid/out_ready/out_inst/out_pc to decode; redirect_valid/redirect_pc
// flush and restart; new_pc/update_pc advance the regfile PC per accepted inst.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                   DEPTH    = 2,
  parameter logic [BIT_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 nreset,
  output logic                 imem_req,
  output logic [BIT_WIDTH-1:0] imem_addr,
  input  logic [BIT_WIDTH-1:0] imem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_inst,
  output logic [BIT_WIDTH-1:0] out_pc,
  input  logic                 redirect_valid,
  input  logic [BIT_WIDTH-1:0] redirect_pc,
  output logic [BIT_WIDTH-1:0] new_pc,
  output logic                 update_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [BIT_WIDTH-1:0] fetch_addr;
  logic [BIT_WIDTH-1:0] req_pc;
  logic                 inflight;
  logic                 epoch;
  logic                 req_epoch;
  logic [CW-1:0]        count;
  logic [CW:0]          occupancy;
  logic                 issue;
  logic                 push;
  logic                 pop;
  fetch_entry_t         head;
  fetch_entry_t         push_entry;
  logic                 unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  // Slots committed after this edge: a pop this cycle frees its slot before
  // the response to a new request lands, which keeps 1 inst/cycle at DEPTH=2.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);

  // nreset gates the request so it drops as soon as reset asserts.
  assign issue     = nreset && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
  assign imem_req  = issue;
  assign imem_addr = fetch_addr;

  // A response belongs to the current stream only if no redirect intervened.
  assign push            = inflight && (req_epoch == epoch) && !redirect_valid;
  assign push_entry.inst = imem_rdata;
  assign push_entry.pc   = req_pc;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      fetch_addr <= {RESET_PC[BIT_WIDTH-1:2], 2'b00};
      req_pc     <= '0;
      inflight   <= 1'b0;
      epoch      <= 1'b0;
      req_epoch  <= 1'b0;
    end else if (redirect_valid) begin
      fetch_addr <= {redirect_pc[BIT_WIDTH-1:2], 2'b00};
      inflight   <= 1'b0;
      epoch      <= ~epoch;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_addr <= fetch_addr + BIT_WIDTH'(INST_BYTES);
        req_pc     <= fetch_addr;
        req_epoch  <= epoch;
      end
    end
  end

  fetch_unit_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nreset    (nreset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  assign out_inst  = head.inst;
  assign out_pc    = head.pc;
  assign new_pc    = out_valid ? (head.pc + BIT_WIDTH'(INST_BYTES)) : '0;
  // The regfile forbids a PC update in the same cycle as a PC write.
  assign update_pc = pop && !redirect_valid;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (nreset) begin
      assert (!(update_pc && redirect_valid)) else $error("update_pc with redirect");
      assert (imem_addr[1:0] == 2'b00) else $error("misaligned imem_addr");
    end
  end
`endif

endmodule
